// File: rtl/hmi_pkg.sv
// Shared constants and FSM state type for the host-link response packetiser.
package hmi_pkg;
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    localparam int         HDR_BYTES    = 3;   // sync, device-select, packet address

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LOAD,
        ST_ACK,
        ST_WAIT
    } st_t;
endpackage

// File: rtl/hmi_byte_hs.sv
// Per-byte UART handshake: issues the registered start pulse on LOAD and
// reports when the transmitter has accepted and then finished the byte.
module hmi_byte_hs
    import hmi_pkg::*;
(
    input  logic clk,
    input  logic res_n,
    input  st_t  i_state,
    input  logic i_tx_busy,
    output logic o_tx_start,
    output logic o_ack_seen,
    output logic o_byte_done
);
    logic r_tx_start;

    // Start is high only in the cycle after LOAD, so exactly one pulse per byte.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) r_tx_start <= 1'b0;
        else        r_tx_start <= (i_state == ST_LOAD);
    end

    assign o_tx_start  = r_tx_start;
    assign o_ack_seen  = (i_state == ST_ACK)  &&  i_tx_busy;
    assign o_byte_done = (i_state == ST_WAIT) && !i_tx_busy;
endmodule

// File: rtl/hmi_tx.sv
// Response packetiser: frames sync, select, address, result-store data and an
// XOR checksum, and streams them to the UART one byte at a time.
module hmi_tx
    import hmi_pkg::*;
#(
    parameter int         NBYTES    = 6,
    parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       cmd_read,
    input  logic       cmd_dev_sel,
    input  logic [7:0] dev_sel_byte,
    input  logic [4:0] pkt_addr,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic       busy,
    output logic       done
);
    localparam logic [3:0] IDX_HDR  = 4'(HDR_BYTES);
    localparam logic [3:0] IDX_LAST = 4'(NBYTES + HDR_BYTES);

    st_t        r_state, w_next;
    logic [3:0] r_idx;
    logic [7:0] r_dev, r_csum, r_tx_data, r_rd_addr;
    logic [4:0] r_pkt;
    logic       r_busy, r_done;
    logic       w_start_pkt, w_ack_seen, w_byte_done, w_last, w_next_data;
    logic [3:0] w_nidx;
    logic [2:0] w_didx;
    logic [7:0] w_byte;

    hmi_byte_hs u_hs (
        .clk         (clk),
        .res_n       (res_n),
        .i_state     (r_state),
        .i_tx_busy   (tx_busy),
        .o_tx_start  (tx_start),
        .o_ack_seen  (w_ack_seen),
        .o_byte_done (w_byte_done)
    );

    assign w_start_pkt = (r_state == ST_IDLE) && cmd_read && cmd_dev_sel;
    assign w_last      = (r_idx == IDX_LAST);
    assign w_nidx      = r_idx + 4'd1;
    assign w_next_data = (w_nidx >= IDX_HDR) && (w_nidx < IDX_LAST);
    assign w_didx      = 3'(w_nidx - IDX_HDR);

    // Pick the byte for the current index; data bytes come straight from the store.
    always_comb begin
        w_byte = r_csum;
        case (r_idx)
            4'd0:    w_byte = SYNC_BYTE;
            4'd1:    w_byte = r_dev;
            4'd2:    w_byte = {3'b000, r_pkt};
            default: if (r_idx < IDX_LAST) w_byte = rd_data;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state: ADDR is only inserted ahead of data bytes to give the store a cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start_pkt) w_next = ST_LOAD;
            ST_ADDR: w_next = ST_LOAD;
            ST_LOAD: w_next = ST_ACK;
            ST_ACK:  if (w_ack_seen) w_next = ST_WAIT;
            ST_WAIT: if (w_byte_done) begin
                if (w_last)           w_next = ST_IDLE;
                else if (w_next_data) w_next = ST_ADDR;
                else                  w_next = ST_LOAD;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Capture, byte load with checksum update, and index/address advance.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_idx     <= '0;
            r_dev     <= '0;
            r_pkt     <= '0;
            r_csum    <= '0;
            r_tx_data <= '0;
            r_rd_addr <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start_pkt) begin
                r_dev  <= dev_sel_byte;
                r_pkt  <= pkt_addr;
                r_csum <= '0;
                r_idx  <= '0;
            end
            if (r_state == ST_LOAD) begin
                r_tx_data <= w_byte;
                r_busy    <= 1'b1;
                // Sync is excluded; folding in the checksum byte itself is harmless
                // because the accumulator clears on the next packet.
                if (r_idx != 4'd0) r_csum <= r_csum ^ w_byte;
            end
            if ((r_state == ST_WAIT) && w_byte_done) begin
                if (w_last) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_idx <= w_nidx;
                    if (w_next_data) r_rd_addr <= {r_pkt, w_didx};
                end
            end
        end
    end

    assign tx_data = r_tx_data;
    assign rd_addr = r_rd_addr;
    assign busy    = r_busy;
    assign done    = r_done;
endmodule
